// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REG_AW_DEFAULT = 5;

    typedef enum logic [0:0] {
        StIdle,
        StLstall
    } hz_state_e;

endpackage

// File: rtl/hazard_dep_cmp.sv
// One source-register vs EX destination compare; x0 and unused sources never match.
module hazard_dep_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_used,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hit
);

    assign hit = src_used && (ex_rd != '0) && (ex_rd == src);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch / multicycle hazard control for a 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEFAULT,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              ex_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              control_sel,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned BW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int          LAT_M2 = int'(LOAD_LAT) - 2;
    localparam logic [BW-1:0] CNT_INIT = (LOAD_LAT > 1) ? BW'(LAT_M2) : '0;

    hz_state_e     state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic          hit_rs1, hit_rs2, load_use;

    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_rs1 (
        .src      (id_rs1),
        .src_used (id_rs1_used),
        .ex_rd    (ex_rd),
        .hit      (hit_rs1)
    );

    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp_rs2 (
        .src      (id_rs2),
        .src_used (id_rs2_used),
        .ex_rd    (ex_rd),
        .hit      (hit_rs2)
    );

    assign load_use = ex_mem_read && (hit_rs1 || hit_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The hit cycle itself is the first bubble; LSTALL supplies the remaining LOAD_LAT-1.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        control_sel = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        if (!rst_n) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = StIdle;
            cnt_d       = '0;
        end else if (ex_busy) begin
            control_sel = 1'b1;
        end else if (state_q == StLstall) begin
            id_ex_write = 1'b1;
            if (cnt_q == '0) begin
                state_d = StIdle;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (load_use) begin
            id_ex_write = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = StLstall;
                cnt_d   = CNT_INIT;
            end
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
            control_sel = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench: two hazard_unit instances (LOAD_LAT 1 and 3) against a bubble-count model.
module tb_hazard_unit;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct {
        string      tag;
        logic [5:0] o0;
        logic [5:0] o1;
        longint     s0;
        longint     s1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_busy;

    logic        pc_a, ifid_a, idex_a, cs_a, iff_a, idf_a;
    logic        pc_b, ifid_b, idex_b, cs_b, iff_b, idf_b;
    logic [31:0] stall_a;
    logic [3:0]  stall_b;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Model state per lane: forced bubbles still owed, and stall-cycle count.
    int     lat [2] = '{1, 3};
    longint smax[2] = '{64'hFFFF_FFFF, 64'd15};
    int     left[2] = '{0, 0};
    int     nleft[2] = '{0, 0};
    longint cnt [2] = '{0, 0};
    longint ncnt[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_busy         (ex_busy),
        .pc_write        (pc_a),
        .if_id_write     (ifid_a),
        .id_ex_write     (idex_a),
        .control_sel     (cs_a),
        .if_id_flush     (iff_a),
        .id_ex_flush     (idf_a),
        .stall_cycles    (stall_a)
    );

    hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_busy         (ex_busy),
        .pc_write        (pc_b),
        .if_id_write     (ifid_b),
        .id_ex_write     (idex_b),
        .control_sel     (cs_b),
        .if_id_flush     (iff_b),
        .id_ex_flush     (idf_b),
        .stall_cycles    (stall_b)
    );

    function automatic stim_t st(input logic r, input int rs1, input int rs2, input logic u1,
                                 input logic u2, input int rd, input logic mr, input logic br,
                                 input logic busy);
        stim_t s;
        s.rst_n = r;
        s.rs1   = 5'(rs1);
        s.rs2   = 5'(rs2);
        s.u1    = u1;
        s.u2    = u2;
        s.rd    = 5'(rd);
        s.mr    = mr;
        s.br    = br;
        s.busy  = busy;
        return s;
    endfunction

    // Output vector order: {pc_write, if_id_write, id_ex_write, control_sel, if_id_flush, id_ex_flush}
    task automatic model(input stim_t s, input int ln, output logic [5:0] o);
        logic hit;
        hit = s.mr && (s.rd != 0) && ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        nleft[ln] = left[ln];
        ncnt[ln]  = cnt[ln];
        if (!s.rst_n) begin
            o = 6'b000000;
            nleft[ln] = 0;
            ncnt[ln]  = 0;
        end else begin
            if (s.br) begin
                o = 6'b111011;
                nleft[ln] = 0;
            end else if (s.busy) begin
                o = 6'b000100;
            end else if (left[ln] > 0) begin
                o = 6'b001000;
                nleft[ln] = left[ln] - 1;
            end else if (hit) begin
                o = 6'b001000;
                nleft[ln] = lat[ln] - 1;
            end else begin
                o = 6'b111100;
            end
            if (!o[5] && cnt[ln] < smax[ln]) ncnt[ln] = cnt[ln] + 1;
        end
    endtask

    task automatic step(input stim_t s, input string tag);
        exp_t e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            left[i] = nleft[i];
            cnt[i]  = ncnt[i];
        end
        #1;
        rst_n           = s.rst_n;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_rs1_used     = s.u1;
        id_rs2_used     = s.u2;
        ex_rd           = s.rd;
        ex_mem_read     = s.mr;
        ex_branch_taken = s.br;
        ex_busy         = s.busy;
        if (!s.rst_n) begin
            left = '{0, 0};
            cnt  = '{0, 0};
        end
        e.tag = tag;
        model(s, 0, e.o0);
        model(s, 1, e.o1);
`ifdef HAZARD_PERF_CNT_EN
        e.s0 = cnt[0];
        e.s1 = cnt[1];
`else
        e.s0 = 0;
        e.s1 = 0;
`endif
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if ({pc_a, ifid_a, idex_a, cs_a, iff_a, idf_a} !== e.o0) begin
                errors++;
                $display("FAIL %s lat1 outputs: got %b expected %b", e.tag,
                         {pc_a, ifid_a, idex_a, cs_a, iff_a, idf_a}, e.o0);
            end
            if ({pc_b, ifid_b, idex_b, cs_b, iff_b, idf_b} !== e.o1) begin
                errors++;
                $display("FAIL %s lat3 outputs: got %b expected %b", e.tag,
                         {pc_b, ifid_b, idex_b, cs_b, iff_b, idf_b}, e.o1);
            end
            if (longint'(stall_a) != e.s0) begin
                errors++;
                $display("FAIL %s lat1 stall_cycles: got %0d expected %0d", e.tag, stall_a, e.s0);
            end
            if (longint'(stall_b) != e.s1) begin
                errors++;
                $display("FAIL %s lat3 stall_cycles: got %0d expected %0d", e.tag, stall_b, e.s1);
            end
        end
    end

    initial begin
        stim_t idle, hit1;
        idle = st(1, 0, 0, 0, 0, 0, 0, 0, 0);
        hit1 = st(1, 5, 0, 1, 0, 5, 1, 0, 0);
        rst_n = 1'b0;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_busy} = '0;

        step(st(0, 5, 0, 1, 0, 5, 1, 0, 0), "reset");
        step(st(0, 5, 0, 1, 0, 5, 1, 1, 1), "reset_all");
        step(idle, "idle");
        // Single load-use hit, then the load leaves EX.
        step(hit1, "lu_hit");
        for (int i = 0; i < 4; i++) step(idle, "lu_after");
        step(st(1, 0, 0, 0, 1, 0, 1, 0, 0), "x0_nohit");
        step(st(1, 0, 7, 0, 0, 7, 1, 0, 0), "unused_nohit");
        step(st(1, 3, 7, 0, 1, 7, 1, 0, 0), "rs2_hit");
        for (int i = 0; i < 3; i++) step(idle, "rs2_after");
        // Branch during LSTALL aborts it.
        step(hit1, "br_hit");
        step(idle, "br_lstall1");
        step(st(1, 0, 0, 0, 0, 0, 0, 1, 0), "br_taken");
        step(idle, "br_after");
        step(idle, "br_after2");
        // Busy holds everything; bubbles follow once busy drops.
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0), "busy_rst");
        for (int i = 0; i < 4; i++) step(st(1, 5, 0, 1, 0, 5, 1, 0, 1), "busy_hit");
        step(hit1, "busy_release");
        for (int i = 0; i < 4; i++) step(idle, "busy_after");
        // Reset pulse mid-LSTALL.
        step(hit1, "rst_hit");
        step(st(0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_mid");
        step(idle, "rst_release");
        step(idle, "rst_release2");
        // Busy in LSTALL freezes the count.
        step(hit1, "frz_hit");
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 1), "frz_busy");
        step(st(1, 0, 0, 0, 0, 0, 0, 0, 1), "frz_busy2");
        for (int i = 0; i < 4; i++) step(idle, "frz_after");

        for (int i = 0; i < 500; i++) begin
            stim_t s;
            s.rst_n = ($urandom_range(0, 99) >= 3);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom_range(0, 1));
            s.u2    = 1'($urandom_range(0, 1));
            s.rd    = 5'($urandom_range(0, 3));
            s.mr    = 1'($urandom_range(0, 1));
            s.br    = ($urandom_range(0, 99) < 8);
            s.busy  = ($urandom_range(0, 99) < 15);
            step(s, "random");
        end
        step(idle, "tail");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
